ruta_datos_control: RTL and testbench

Fixed-point multiply-accumulate datapath that executes the per-sample control-law computation. It sits directly downstream of the control-sequencing FSM (`ControlMux`) and consumes its outputs each cycle:

- `sel_const` picks a coefficient.
- `sel_fun` picks an operand.
- `sel_acum` picks the accumulator action.
- `Senal` captures an intermediate term.
- `Band_Listo` publishes the result.

Both blocks share `Bandera` as the start-of-sample strobe. This block latches the new input sample, runs one MAC step per cycle, and emits a saturated output with a one-cycle valid pulse.

---
 rtl/ruta_datos_control.sv | 149 ++++++++++++++
 tb/tb_ruta_datos_control.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ruta_datos_control.sv
// Fixed-point multiply-accumulate datapath for the per-sample control law.
// Driven cycle by cycle by the ControlMux sequencer; publishes a saturated result with a valid pulse.
module ruta_datos_control #(
    parameter int             N    = 16,
    parameter int             FRAC = 8,
    parameter logic [N-1:0]   C0   = 16'h0100,
    parameter logic [N-1:0]   C1   = 16'h0080,
    parameter logic [N-1:0]   C2   = 16'hFF80,
    parameter logic [N-1:0]   C3   = 16'h0040,
    parameter logic [N-1:0]   C4   = 16'h0100
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         Bandera,
    input  logic [N-1:0] x_in,
    input  logic [2:0]   sel_const,
    input  logic [1:0]   sel_fun,
    input  logic [1:0]   sel_acum,
    input  logic         Senal,
    input  logic         Band_Listo,
    output logic [N-1:0] y_out,
    output logic         y_valid,
    output logic         y_sat
);

    localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MAX_NEG = {1'b1, {(N-1){1'b0}}};

    localparam logic [1:0] ACC_CLR  = 2'b00;
    localparam logic [1:0] ACC_ADD  = 2'b01;
    localparam logic [1:0] ACC_LOAD = 2'b10;
    localparam logic [1:0] ACC_HOLD = 2'b11;

    logic [N-1:0] r_x_k;
    logic [N-1:0] r_acc;
    logic [N-1:0] r_m_reg;
    logic [N-1:0] r_y_k1;
    logic [N-1:0] r_y_k2;
    logic [N-1:0] r_y_out;
    logic         r_sat_flag;
    logic         r_listo_q;
    logic         r_y_valid;
    logic         r_y_sat;

    logic [N-1:0]          w_coef;
    logic [N-1:0]          w_opnd;
    logic signed [2*N-1:0] w_prod_full;
    logic signed [2*N-1:0] w_shift;
    logic                  w_prod_ovf;
    logic [N-1:0]          w_prod;
    logic [N:0]            w_sum;
    logic                  w_sum_ovf;
    logic [N-1:0]          w_sum_sat;
    logic [N-1:0]          w_acc_next;
    logic                  w_sat_now;
    logic                  w_publish;

    // NOTE: every signal written in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        w_coef = '0;
        case (sel_const)
            3'd0:    w_coef = C0;
            3'd1:    w_coef = C1;
            3'd2:    w_coef = C2;
            3'd3:    w_coef = C3;
            3'd4:    w_coef = C4;
            default: w_coef = '0;
        endcase
    end

    always_comb begin
        w_opnd = '0;
        case (sel_fun)
            2'b01:   w_opnd = r_x_k;
            2'b10:   w_opnd = r_y_k1;
            2'b11:   w_opnd = r_m_reg;
            default: w_opnd = '0;
        endcase
    end

    // Arithmetic shift floors the scaled product; clamp when the kept upper bits disagree.
    assign w_prod_full = $signed(w_coef) * $signed(w_opnd);
    assign w_shift     = w_prod_full >>> FRAC;
    assign w_prod_ovf  = !((&w_shift[2*N-1:N-1]) || !(|w_shift[2*N-1:N-1]));
    assign w_prod      = w_prod_ovf ? (w_shift[2*N-1] ? MAX_NEG : MAX_POS) : w_shift[N-1:0];

    assign w_sum     = {r_acc[N-1], r_acc} + {w_prod[N-1], w_prod};
    assign w_sum_ovf = w_sum[N] ^ w_sum[N-1];
    assign w_sum_sat = w_sum_ovf ? (w_sum[N] ? MAX_NEG : MAX_POS) : w_sum[N-1:0];

    always_comb begin
        w_acc_next = r_acc;
        w_sat_now  = w_prod_ovf;
        case (sel_acum)
            ACC_CLR:  w_acc_next = '0;
            ACC_ADD: begin
                w_acc_next = w_sum_sat;
                w_sat_now  = w_prod_ovf | w_sum_ovf;
            end
            ACC_LOAD: w_acc_next = w_prod;
            ACC_HOLD: w_acc_next = r_acc;
            default:  w_acc_next = r_acc;
        endcase
    end

    assign w_publish = Band_Listo & ~r_listo_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x_k      <= '0;
            r_acc      <= '0;
            r_m_reg    <= '0;
            r_y_k1     <= '0;
            r_y_k2     <= '0;
            r_y_out    <= '0;
            r_sat_flag <= 1'b0;
            r_listo_q  <= 1'b0;
            r_y_valid  <= 1'b0;
            r_y_sat    <= 1'b0;
        end else if (Bandera) begin
            // New sample starts: any same-cycle step, capture or publish is discarded.
            r_x_k      <= x_in;
            r_acc      <= '0;
            r_sat_flag <= 1'b0;
            r_listo_q  <= 1'b0;
            r_y_valid  <= 1'b0;
        end else begin
            r_acc      <= w_acc_next;
            r_sat_flag <= r_sat_flag | w_sat_now;
            r_listo_q  <= Band_Listo;
            r_y_valid  <= w_publish;
            if (Senal) begin
                r_m_reg <= w_acc_next;
            end
            if (w_publish) begin
                r_y_out <= w_acc_next;
                r_y_sat <= r_sat_flag | w_sat_now;
                r_y_k2  <= r_y_k1;
                r_y_k1  <= w_acc_next;
            end
        end
    end

    assign y_out   = r_y_out;
    assign y_valid = r_y_valid;
    assign y_sat   = r_y_sat;

endmodule

// File: tb/tb_ruta_datos_control.sv
// Directed bench for ruta_datos_control: stimulus pushes expected results, a monitor pops them on y_valid.
module tb_ruta_datos_control;

    typedef struct {
        logic [15:0] y;
        logic        sat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        Bandera;
    logic [15:0] x_in;
    logic [2:0]  sel_const;
    logic [1:0]  sel_fun;
    logic [1:0]  sel_acum;
    logic        Senal;
    logic        Band_Listo;
    logic [15:0] y_out;
    logic        y_valid;
    logic        y_sat;

    exp_t sb_q[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   n_pulses  = 0;
    int   n_pushed  = 0;

    ruta_datos_control dut (
        .clk        (clk),
        .reset      (reset),
        .Bandera    (Bandera),
        .x_in       (x_in),
        .sel_const  (sel_const),
        .sel_fun    (sel_fun),
        .sel_acum   (sel_acum),
        .Senal      (Senal),
        .Band_Listo (Band_Listo),
        .y_out      (y_out),
        .y_valid    (y_valid),
        .y_sat      (y_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [15:0] y, input logic sat);
        exp_t e;
        e.y   = y;
        e.sat = sat;
        sb_q.push_back(e);
        n_pushed++;
    endtask

    // One cycle of control: present inputs, let the edge happen, settle 1 time unit past it.
    task automatic step(input logic b, input logic [15:0] x, input logic [2:0] sc,
                        input logic [1:0] sf, input logic [1:0] sa, input logic sn, input logic bl);
        Bandera    = b;
        x_in       = x;
        sel_const  = sc;
        sel_fun    = sf;
        sel_acum   = sa;
        Senal      = sn;
        Band_Listo = bl;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (y_valid === 1'b1) begin
            exp_t e;
            n_pulses++;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got y_out=%h y_sat=%b expected no pulse at %0t", y_out, y_sat, $time);
            end else begin
                e = sb_q.pop_front();
                check("y_out", {16'h0, y_out}, {16'h0, e.y});
                check("y_sat", {31'h0, y_sat}, {31'h0, e.sat});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with random control inputs.
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1'($urandom), 16'($urandom), 3'($urandom), 2'($urandom), 2'($urandom),
                 1'($urandom), 1'($urandom));
        end
        check("rst_y_out",   {16'h0, y_out},   32'h0);
        check("rst_y_valid", {31'h0, y_valid}, 32'h0);
        check("rst_y_sat",   {31'h0, y_sat},   32'h0);
        reset = 1'b0;

        // y_k1 is zero after reset, so an operand-10 product is zero.
        step(1, 16'h1234, 0, 2'b00, 2'b11, 0, 0);
        step(0, 16'h0000, 0, 2'b10, 2'b10, 0, 1); push(16'h0000, 0);
        step(0, 16'h0000, 0, 2'b00, 2'b11, 0, 0);

        // Plain load of C0*x and publish.
        step(1, 16'h0200, 0, 2'b00, 2'b11, 0, 0);
        step(0, 16'h0000, 0, 2'b01, 2'b10, 0, 1); push(16'h0200, 0);
        step(0, 16'h0000, 0, 2'b00, 2'b11, 0, 0);

        // 0.5x - 0.5x cancels to zero; y_k2 takes the previous result.
        step(1, 16'h0200, 0, 2'b00, 2'b11, 0, 0);
        step(0, 16'h0000, 1, 2'b01, 2'b10, 0, 0);
        step(0, 16'h0000, 2, 2'b01, 2'b01, 0, 1); push(16'h0000, 0);
        check("y_k2_after_cancel", {16'h0, dut.r_y_k2}, 32'h0200);
        step(0, 16'h0000, 0, 2'b00, 2'b11, 0, 0);

        // Positive and negative accumulator saturation, then flag cleared by the next sample.
        step(1, 16'h7F00, 0, 2'b00, 2'b11, 0, 0);
        step(0, 16'h0000, 0, 2'b01, 2'b10, 0, 0);
        step(0, 16'h0000, 0, 2'b01, 2'b01, 0, 1); push(16'h7FFF, 1);
        step(0, 16'h0000, 0, 2'b00, 2'b11, 0, 0);
        step(1, 16'h8100, 0, 2'b00, 2'b11, 0, 0);
        step(0, 16'h0000, 0, 2'b01, 2'b10, 0, 0);
        step(0, 16'h0000, 0, 2'b01, 2'b01, 0, 1); push(16'h8000, 1);
        step(0, 16'h0000, 0, 2'b00, 2'b11, 0, 0);
        step(1, 16'h0100, 0, 2'b00, 2'b11, 0, 0);
        step(0, 16'h0000, 0, 2'b01, 2'b10, 0, 1); push(16'h0100, 0);
        step(0, 16'h0000, 0, 2'b00, 2'b11, 0, 0);

        // Capture 0x0180 into m_reg, scale by 0.25, hold Band_Listo for four cycles.
        step(1, 16'h0300, 0, 2'b00, 2'b11, 0, 0);
        step(0, 16'h0000, 1, 2'b01, 2'b10, 1, 0);
        step(0, 16'h0000, 3, 2'b11, 2'b10, 0, 1); push(16'h0060, 0);
        for (int i = 0; i < 3; i++) step(0, 16'h0000, 0, 2'b00, 2'b11, 0, 1);
        check("y_k1_single_update", {16'h0, dut.r_y_k1}, 32'h0060);
        step(0, 16'h0000, 0, 2'b00, 2'b11, 0, 0);

        // Operand 10 reads the previous result: 0.5 * 0x0060.
        step(1, 16'h0000, 0, 2'b00, 2'b11, 0, 0);
        step(0, 16'h0000, 1, 2'b10, 2'b10, 0, 1); push(16'h0030, 0);
        check("y_k2_shift", {16'h0, dut.r_y_k2}, 32'h0060);
        step(0, 16'h0000, 0, 2'b00, 2'b11, 0, 0);

        // Floor on negative products: 0.5 * (-1/256) rounds to -1/256, not zero.
        step(1, 16'hFFFF, 0, 2'b00, 2'b11, 0, 0);
        step(0, 16'h0000, 1, 2'b01, 2'b10, 0, 1); push(16'hFFFF, 0);
        step(0, 16'h0000, 0, 2'b00, 2'b11, 0, 0);

        // Bandera colliding with a publish edge drops it and clears acc; new x_k is used afterwards.
        step(1, 16'h0400, 0, 2'b00, 2'b11, 0, 0);
        step(0, 16'h0000, 0, 2'b01, 2'b10, 0, 0);
        step(1, 16'h0010, 0, 2'b01, 2'b01, 0, 1);
        step(0, 16'h0000, 0, 2'b00, 2'b01, 0, 0);
        step(0, 16'h0000, 0, 2'b01, 2'b01, 0, 1); push(16'h0010, 0);
        step(0, 16'h0000, 0, 2'b00, 2'b11, 0, 0);

        // Reset mid-sample with a publish edge pending: no pulse, all state cleared.
        step(1, 16'h0500, 0, 2'b00, 2'b11, 0, 0);
        step(0, 16'h0000, 0, 2'b01, 2'b10, 0, 0);
        reset = 1'b1;
        step(0, 16'h0000, 0, 2'b01, 2'b01, 0, 1);
        reset = 1'b0;
        check("mid_rst_y_out", {16'h0, y_out},      32'h0);
        check("mid_rst_y_k1",  {16'h0, dut.r_y_k1}, 32'h0);
        check("mid_rst_x_k",   {16'h0, dut.r_x_k},  32'h0);
        step(0, 16'h0000, 0, 2'b00, 2'b11, 0, 0);
        step(0, 16'h0000, 0, 2'b01, 2'b01, 0, 1); push(16'h0000, 0);
        step(0, 16'h0000, 0, 2'b00, 2'b11, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", sb_q.size(), 32'h0);
        check("pulse_count", n_pulses, n_pushed);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
